nibble_serial_subtractor: RTL and testbench

- Multi-word subtract sequencer that sits directly upstream of the team's 4-bit parallel full subtractor.
- It latches WIDTH-bit operands and drives one 4-bit slice per clock into the subtractor, LSB nibble first.
- It chains the borrow between slices and collects the returned difference nibbles into a WIDTH-bit result.
- Net effect: wide subtraction from a single 4-bit datapath, at the cost of WIDTH/4 cycles.

---
 rtl/nibble_serial_subtractor.sv | 188 ++++++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// ------------------------
// Performs a wide subtraction on an external 4-bit parallel subtractor by
// feeding it one operand slice per clock, LSB nibble first. The borrow is
// chained between slices. The returned difference nibbles are gathered into
// a WIDTH-bit result.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active-high; overrides every other input
//   start          begin an operation (only sampled while idle)
//   op_a, op_b     minuend / subtrahend, latched when start is accepted
//   bin            initial borrow-in, latched when start is accepted
//   busy           an operation is in progress
//   done           one-cycle completion pulse
//   diff           (op_a - op_b - bin) mod 2^WIDTH, updated only at completion
//   bout           final borrow-out (op_a < op_b + bin)
//   sub_a, sub_b   current operand slices to the external subtractor
//   sub_ci         current borrow-in to the external subtractor
//   sub_d, sub_co  difference nibble / borrow-out returned by the subtractor
//
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [3:0]       sub_a,
    output logic [3:0]       sub_b,
    output logic             sub_ci,
    input  logic [3:0]       sub_d,
    input  logic             sub_co
);

    localparam int NIB   = WIDTH / 4;
    // A single-slice instance still needs a one-bit index register.
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Returns nibble number sel of word. A shift is used instead of an
    // indexed part-select so that the index width never has to match the
    // word width exactly, including when WIDTH is 4.
    function automatic logic [3:0] get_nibble(input logic [WIDTH-1:0] word,
                                              input logic [IDX_W-1:0] sel);
        logic [WIDTH-1:0] shifted;
        shifted = word >> {sel, 2'b00};
        return shifted[3:0];
    endfunction

    // Returns word with nibble number sel replaced by nib.
    function automatic logic [WIDTH-1:0] put_nibble(input logic [WIDTH-1:0] word,
                                                    input logic [IDX_W-1:0] sel,
                                                    input logic [3:0]       nib);
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] ins;
        mask = WIDTH'(4'hF) << {sel, 2'b00};
        ins  = WIDTH'(nib) << {sel, 2'b00};
        return (word & ~mask) | ins;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             brw_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             done_r;
    logic             accept_s;
    logic             last_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic, start acceptance and last-slice detection.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == IDX_LAST) begin
                    last_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Current slice to the external subtractor. Outputs are forced to zero
    // when idle so that the subtractor sees quiet inputs.
    always_comb begin
        sub_a  = 4'h0;
        sub_b  = 4'h0;
        sub_ci = 1'b0;
        if (state_r == ST_RUN) begin
            sub_a  = get_nibble(a_r, idx_r);
            sub_b  = get_nibble(b_r, idx_r);
            sub_ci = brw_r;
        end else begin
            sub_a  = 4'h0;
            sub_b  = 4'h0;
            sub_ci = 1'b0;
        end
    end

    // The accumulator with the returned nibble merged in. At the last slice
    // this value is the complete result, so diff never shows a partial value.
    always_comb begin
        acc_next_s = put_nibble(acc_r, idx_r, sub_d);
    end

    // Operand latches, borrow chain, slice index, result and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            brw_r  <= 1'b0;
            idx_r  <= IDX_ZERO;
            acc_r  <= {WIDTH{1'b0}};
            diff_r <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= last_s;
            if (accept_s) begin
                a_r   <= op_a;
                b_r   <= op_b;
                brw_r <= bin;
                idx_r <= IDX_ZERO;
                acc_r <= {WIDTH{1'b0}};
            end else if (state_r == ST_RUN) begin
                acc_r <= acc_next_s;
                brw_r <= sub_co;
                idx_r <= idx_r + IDX_ONE;
                if (last_s) begin
                    diff_r <= acc_next_s;
                    bout_r <= sub_co;
                end
            end
        end
    end

    assign busy = (state_r == ST_RUN);
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Testbench for nibble_serial_subtractor. A behavioural 4-bit parallel
// subtractor is attached to the sub_* ports of a 16-bit and a 4-bit
// instance. Directed vectors are used, and the expected results are worked
// out by hand.

module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;

    // 16-bit instance
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic [3:0]  sub_a;
    logic [3:0]  sub_b;
    logic        sub_ci;
    logic [3:0]  sub_d;
    logic        sub_co;
    logic [4:0]  sub_res;

    // 4-bit instance
    logic        start4;
    logic [3:0]  op_a4;
    logic [3:0]  op_b4;
    logic        bin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  diff4;
    logic        bout4;
    logic [3:0]  sub_a4;
    logic [3:0]  sub_b4;
    logic        sub_ci4;
    logic [3:0]  sub_d4;
    logic        sub_co4;
    logic [4:0]  sub_res4;

    int          total = 0;
    int          bad = 0;
    logic [15:0] last_diff;
    logic [3:0]  ci_seq;
    int          dones;

    always #5 clk = ~clk;

    // 4-bit parallel subtractors. A negative result wraps, which sets bit 4.
    assign sub_res  = {1'b0, sub_a}  - {1'b0, sub_b}  - {4'b0000, sub_ci};
    assign sub_d    = sub_res[3:0];
    assign sub_co   = sub_res[4];
    assign sub_res4 = {1'b0, sub_a4} - {1'b0, sub_b4} - {4'b0000, sub_ci4};
    assign sub_d4   = sub_res4[3:0];
    assign sub_co4  = sub_res4[4];

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .bin(bin), .busy(busy), .done(done), .diff(diff), .bout(bout),
        .sub_a(sub_a), .sub_b(sub_b), .sub_ci(sub_ci),
        .sub_d(sub_d), .sub_co(sub_co)
    );

    nibble_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_a(op_a4), .op_b(op_b4),
        .bin(bin4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4),
        .sub_a(sub_a4), .sub_b(sub_b4), .sub_ci(sub_ci4),
        .sub_d(sub_d4), .sub_co(sub_co4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One 16-bit operation: a single-cycle start, four busy cycles with diff
    // held, then a done pulse that carries the new result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [15:0] ed, input logic eb,
                          output logic [3:0] cis);
        op_a  = a;
        op_b  = b;
        bin   = bi;
        start = 1'b1;
        tick;
        start = 1'b0;
        cis = 4'h0;
        for (int i = 0; i < 4; i++) begin
            cis[i] = sub_ci;
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_hold"}, 32'(diff), 32'(last_diff));
            tick;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        last_diff = ed;
        tick;
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op_a   = 16'h0000;
        op_b   = 16'h0000;
        bin    = 1'b0;
        start4 = 1'b0;
        op_a4  = 4'h0;
        op_b4  = 4'h0;
        bin4   = 1'b0;
        last_diff = 16'h0000;
        tick;
        tick;
        rst = 1'b0;

        // reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_sub", 32'({sub_a, sub_b, sub_ci}), 32'd0);
        check("rst4_busy", 32'(busy4), 32'd0);

        // 1: basic, with the borrow rippling out of slice 0
        run_op("t1", 16'h1234, 16'h0FFF, 1'b0, 16'h0235, 1'b0, ci_seq);
        check("t1_ciseq", 32'(ci_seq), 32'(4'b1110));

        // 2: wrap-around, borrow-in, and a ripple across three slices
        run_op("t2a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, ci_seq);
        run_op("t2b", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, ci_seq);
        run_op("t2c", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, ci_seq);

        // 3: start while busy is ignored
        op_a  = 16'h00FF;
        op_b  = 16'h000F;
        bin   = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        op_a  = 16'hFFFF;
        op_b  = 16'h0001;
        start = 1'b1;
        tick;
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) begin
                dones++;
                check("t3_diff", 32'(diff), 32'h00F0);
                check("t3_bout", 32'(bout), 32'd0);
            end
            tick;
        end
        check("t3_ndone", 32'(dones), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);
        last_diff = 16'h00F0;

        // 4: start held high, accepted again in the done cycle
        op_a  = 16'h5000;
        op_b  = 16'h0001;
        bin   = 1'b0;
        start = 1'b1;
        tick;
        op_a  = 16'hABCD;
        op_b  = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            check("t4_busy1", 32'(busy), 32'd1);
            check("t4_hold1", 32'(diff), 32'(last_diff));
            tick;
        end
        check("t4_done1", 32'(done), 32'd1);
        check("t4_diff1", 32'(diff), 32'h4FFF);
        check("t4_bout1", 32'(bout), 32'd0);
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4_busy2", 32'(busy), 32'd1);
            check("t4_nodone2", 32'(done), 32'd0);
            check("t4_hold2", 32'(diff), 32'h4FFF);
            tick;
        end
        check("t4_done2", 32'(done), 32'd1);
        check("t4_diff2", 32'(diff), 32'h9ABC);
        check("t4_bout2", 32'(bout), 32'd0);
        tick;
        check("t4_pulse", 32'(done), 32'd0);

        // 5: reset during the second RUN cycle; a start issued with it is ignored
        op_a  = 16'h5555;
        op_b  = 16'h1111;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst   = 1'b1;
        start = 1'b1;
        tick;
        rst   = 1'b0;
        start = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_diff", 32'(diff), 32'd0);
        check("t5_bout", 32'(bout), 32'd0);
        check("t5_sub", 32'({sub_a, sub_b, sub_ci}), 32'd0);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) dones++;
            tick;
        end
        check("t5_ndone", 32'(dones), 32'd0);
        last_diff = 16'h0000;
        run_op("t5b", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, ci_seq);

        // 6: single-slice instance
        op_a4  = 4'h6;
        op_b4  = 4'h9;
        bin4   = 1'b1;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        check("t6_busy", 32'(busy4), 32'd1);
        check("t6_slice", 32'({sub_a4, sub_b4, sub_ci4}), 32'({4'h6, 4'h9, 1'b1}));
        check("t6_nodone", 32'(done4), 32'd0);
        tick;
        check("t6_done", 32'(done4), 32'd1);
        check("t6_idle", 32'(busy4), 32'd0);
        check("t6_diff", 32'(diff4), 32'hC);
        check("t6_bout", 32'(bout4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
